// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then shifts
// one command byte, odd parity and stop on device clocks and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  // state     | meaning
  // IDLE      | bus released, waiting for a command byte
  // INHIBIT   | clock held low for INHIBIT_CYCLES
  // REQ       | clock and data low (start bit), one cycle
  // XFER      | clock released, data/parity/stop shifted on device falling edges
  // ACK       | waiting for the 11th falling edge to sample the device ACK
  // WAIT_IDLE | waiting for clock and data both high before reporting done
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE} state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [2:0]       clk_s, data_s;
  logic [8:0]       shreg, shreg_nxt;
  logic [3:0]       n, n_nxt;
  logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic             err_flag, err_flag_nxt;
  logic             clk_oe_q, clk_oe_nxt;
  logic             data_oe_q, data_oe_nxt;
  logic             done_q, done_nxt;
  logic             ack_err_q, ack_err_nxt;
  logic             timeout_q, timeout_nxt;
  logic             fe, bus_idle, to_active, to_expire;

  // Sync chains reset to 1 so an idle bus never shows a spurious falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s  <= 3'b111;
      data_s <= 3'b111;
    end else begin
      clk_s  <= {clk_s[1:0], ps2_clk_in};
      data_s <= {data_s[1:0], ps2_data_in};
    end
  end

  assign fe        = clk_s[2] & ~clk_s[1];
  assign bus_idle  = clk_s[1] & data_s[1];
  assign to_active = (state == XFER) || (state == ACK) || (state == WAIT_IDLE);
  assign to_expire = to_active && (to_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      shreg     <= '0;
      n         <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      err_flag  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      n         <= n_nxt;
      inh_cnt   <= inh_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      err_flag  <= err_flag_nxt;
      clk_oe_q  <= clk_oe_nxt;
      data_oe_q <= data_oe_nxt;
      done_q    <= done_nxt;
      ack_err_q <= ack_err_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    n_nxt        = n;
    inh_cnt_nxt  = inh_cnt;
    to_cnt_nxt   = to_active ? to_cnt - 1'b1 : to_cnt;
    err_flag_nxt = err_flag;
    clk_oe_nxt   = clk_oe_q;
    data_oe_nxt  = data_oe_q;
    done_nxt     = 1'b0;
    ack_err_nxt  = 1'b0;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx_valid) begin
          shreg_nxt    = {~^tx_data, tx_data};
          inh_cnt_nxt  = INH_W'(INHIBIT_CYCLES - 1);
          err_flag_nxt = 1'b0;
          clk_oe_nxt   = 1'b1;
          state_nxt    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == '0) begin
          data_oe_nxt = 1'b1;
          state_nxt   = REQ;
        end else begin
          inh_cnt_nxt = inh_cnt - 1'b1;
        end
      end
      REQ: begin
        clk_oe_nxt = 1'b0;
        n_nxt      = '0;
        to_cnt_nxt = TO_W'(TIMEOUT_CYCLES - 1);
        state_nxt  = XFER;
      end
      XFER: begin
        if (fe) begin
          n_nxt = n + 4'd1;
          if (n == 4'd9) begin
            data_oe_nxt = 1'b0;
            state_nxt   = ACK;
          end else begin
            // shreg holds {parity, byte}; shifting right walks LSB first into parity
            data_oe_nxt = ~shreg[0];
            shreg_nxt   = {1'b0, shreg[8:1]};
          end
        end
      end
      ACK: begin
        if (fe) begin
          n_nxt        = n + 4'd1;
          err_flag_nxt = data_s[1];
          state_nxt    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (bus_idle) begin
          done_nxt    = 1'b1;
          ack_err_nxt = err_flag;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (to_expire) begin
      clk_oe_nxt  = 1'b0;
      data_oe_nxt = 1'b0;
      done_nxt    = 1'b0;
      ack_err_nxt = 1'b0;
      timeout_nxt = 1'b1;
      state_nxt   = IDLE;
    end
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule
